gshare_pht: RTL and testbench

Parametrised gshare branch predictor for the pipelined ARM core: a pattern history table of 2-bit saturating counters indexed by PC bits XOR a global history register (GHR). It is looked up in Fetch and trained when the branch resolves in Execute. It adds three things a 1-bit table lacks: hysteresis, speculative history with mispredict repair, and a mispredict statistics counter.

---
 rtl/gshare_pht.sv | 110 +++++++++++
 tb/tb_gshare_pht.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gshare_pht.sv
// gshare branch predictor: a table of 2-bit saturating counters indexed by
// the fetched PC index XOR a global history register (GHR).
//
// Port behaviour: there is no valid/ready handshake. lookup_* and resolve_*
// are sampled every cycle their valid is high and are never stalled. A
// resolve_valid pulse is a single-cycle event; resolve_mispredict is only
// ever high in a cycle where resolve_valid is high.
//
// Lookup is combinational (0-cycle latency). The table is read before it is
// written in the same cycle, so a same-cycle resolve to the looked-up index
// is seen by the following lookup. A mispredict repairs the GHR from the
// history carried with the branch and overrides any same-cycle lookup shift.
module gshare_pht #(
  parameter int IDX_W  = 3,
  parameter int HIST_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lookup_valid,
  input  logic [IDX_W-1:0]  lookup_pc_idx,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_index,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              resolve_valid,
  input  logic [IDX_W-1:0]  resolve_index,
  input  logic [HIST_W-1:0] resolve_hist,
  input  logic              resolve_taken,
  input  logic              resolve_predicted,
  output logic              resolve_mispredict,
  output logic [CNT_W-1:0]  mispred_count
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [1:0]        r_pht [DEPTH];
  logic [HIST_W-1:0] r_ghr;
  logic [CNT_W-1:0]  r_mispred_count;

  logic [IDX_W-1:0]  w_index;
  logic              w_pred_taken;
  logic              w_mispredict;
  logic [HIST_W-1:0] w_ghr_shift;
  logic [HIST_W-1:0] w_ghr_repair;
  logic [1:0]        w_cnt_cur;
  logic [1:0]        w_cnt_next;

  // Lookup path: index, prediction and history snapshot, all combinational.
  // The GHR is zero-extended at the MSB side before the XOR.
  always_comb begin
    w_index      = lookup_pc_idx ^ IDX_W'(r_ghr);
    w_pred_taken = r_pht[w_index][1];
  end

  assign pred_taken    = w_pred_taken;
  assign pred_index    = w_index;
  assign pred_hist     = r_ghr;
  assign mispred_count = r_mispred_count;

  // Mispredict detection and the two candidate next-GHR values. Written as a
  // shift-and-or so the same expression also covers a 1-bit history.
  always_comb begin
    w_mispredict = resolve_valid & (resolve_taken != resolve_predicted);
    w_ghr_shift  = (r_ghr << 1) | HIST_W'(w_pred_taken);
    w_ghr_repair = (resolve_hist << 1) | HIST_W'(resolve_taken);
  end

  assign resolve_mispredict = w_mispredict;

  // Saturating next value for the counter being trained.
  always_comb begin
    w_cnt_cur  = r_pht[resolve_index];
    w_cnt_next = w_cnt_cur;
    if (resolve_taken) begin
      if (w_cnt_cur != 2'b11) w_cnt_next = w_cnt_cur + 2'b01;
    end else begin
      if (w_cnt_cur != 2'b00) w_cnt_next = w_cnt_cur - 2'b01;
    end
  end

  // Pattern history table: whole-table reinit on reset, else train on resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_pht[i] <= 2'b01;
    end else if (resolve_valid) begin
      r_pht[resolve_index] <= w_cnt_next;
    end
  end

  // Global history: repair on mispredict wins over the speculative shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ghr <= '0;
    end else if (w_mispredict) begin
      r_ghr <= w_ghr_repair;
    end else if (lookup_valid) begin
      r_ghr <= w_ghr_shift;
    end
  end

  // Mispredict statistics counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mispred_count <= '0;
    end else if (w_mispredict && (r_mispred_count != {CNT_W{1'b1}})) begin
      r_mispred_count <= r_mispred_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gshare_pht.sv
// Bench for gshare_pht: directed steps from the test plan followed by a
// random phase, checked against a behavioural model (integer counters and
// an integer history). A second instance with a 2-bit statistics counter
// shares all inputs so counter saturation can be observed quickly.
module tb_gshare_pht;

  localparam int IDX_W  = 3;
  localparam int HIST_W = 3;
  localparam int DEPTH  = 8;
  localparam int HMOD   = 8;

  logic             clk;
  logic             reset;
  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_pc_idx;
  logic             resolve_valid;
  logic [IDX_W-1:0] resolve_index;
  logic [HIST_W-1:0] resolve_hist;
  logic             resolve_taken;
  logic             resolve_predicted;

  logic              pred_taken,  pred_taken_c2;
  logic [IDX_W-1:0]  pred_index,  pred_index_c2;
  logic [HIST_W-1:0] pred_hist,   pred_hist_c2;
  logic              resolve_mispredict, resolve_mispredict_c2;
  logic [15:0]       mispred_count;
  logic [1:0]        mispred_count_c2;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model
  int m_pht [DEPTH];
  int m_ghr;
  int m_cnt;
  int m_cnt2;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  gshare_pht #(.IDX_W(IDX_W), .HIST_W(HIST_W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc_idx(lookup_pc_idx),
    .pred_taken(pred_taken), .pred_index(pred_index), .pred_hist(pred_hist),
    .resolve_valid(resolve_valid), .resolve_index(resolve_index),
    .resolve_hist(resolve_hist), .resolve_taken(resolve_taken),
    .resolve_predicted(resolve_predicted),
    .resolve_mispredict(resolve_mispredict), .mispred_count(mispred_count)
  );

  gshare_pht #(.IDX_W(IDX_W), .HIST_W(HIST_W), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc_idx(lookup_pc_idx),
    .pred_taken(pred_taken_c2), .pred_index(pred_index_c2), .pred_hist(pred_hist_c2),
    .resolve_valid(resolve_valid), .resolve_index(resolve_index),
    .resolve_hist(resolve_hist), .resolve_taken(resolve_taken),
    .resolve_predicted(resolve_predicted),
    .resolve_mispredict(resolve_mispredict_c2), .mispred_count(mispred_count_c2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_index(input int pc);
    return (pc ^ m_ghr) % DEPTH;
  endfunction

  function automatic int m_pred(input int pc);
    return (m_pht[m_index(pc)] >= 2) ? 1 : 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_pht[i] = 1;
    m_ghr  = 0;
    m_cnt  = 0;
    m_cnt2 = 0;
  endtask

  // driver: one clock cycle of stimulus, checked before and after the edge
  task automatic step(input bit rst, input bit lv, input int pc,
                      input bit rv, input int ridx, input int rhist,
                      input bit rt, input bit rp);
    int exp_pred, exp_mis;
    @(negedge clk);
    reset             = rst;
    lookup_valid      = lv;
    lookup_pc_idx     = IDX_W'(pc);
    resolve_valid     = rv;
    resolve_index     = IDX_W'(ridx);
    resolve_hist      = HIST_W'(rhist);
    resolve_taken     = rt;
    resolve_predicted = rp;
    #1;
    exp_pred = m_pred(pc);
    exp_mis  = (rv && (rt != rp)) ? 1 : 0;
    chk("pred_taken", 32'(pred_taken), 32'(exp_pred));
    chk("pred_index", 32'(pred_index), 32'(m_index(pc)));
    chk("pred_hist",  32'(pred_hist),  32'(m_ghr));
    chk("mispredict", 32'(resolve_mispredict), 32'(exp_mis));
    chk("c2_pred_taken", 32'(pred_taken_c2), 32'(exp_pred));
    // model next state
    if (rst) begin
      m_reset();
    end else begin
      if (rv) m_pht[ridx] = rt ? ((m_pht[ridx] < 3) ? m_pht[ridx] + 1 : 3)
                               : ((m_pht[ridx] > 0) ? m_pht[ridx] - 1 : 0);
      if (exp_mis == 1) begin
        m_ghr  = (rhist * 2 + int'(rt)) % HMOD;
        m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : 65535;
        m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : 3;
      end else if (lv) begin
        m_ghr = (m_ghr * 2 + exp_pred) % HMOD;
      end
    end
    @(posedge clk);
    #1;
    chk("mispred_count",    32'(mispred_count),    32'(m_cnt));
    chk("c2_mispred_count", 32'(mispred_count_c2), 32'(m_cnt2));
  endtask

  // read the counter at a given table index without disturbing state
  task automatic peek(input int idx, input bit exp_taken);
    step(0, 0, idx ^ m_ghr, 0, 0, 0, 0, 0);
    chk("peek_taken", 32'(pred_taken), 32'(exp_taken));
    chk("peek_index", 32'(pred_index), 32'(idx));
  endtask

  initial begin
    int cnt2_exp [5];
    cnt2_exp = '{1, 2, 3, 3, 3};
    reset = 1'b1; lookup_valid = 1'b0; lookup_pc_idx = '0;
    resolve_valid = 1'b0; resolve_index = '0; resolve_hist = '0;
    resolve_taken = 1'b0; resolve_predicted = 1'b0;
    m_reset();

    // reset, then first lookup
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_count", 32'(mispred_count), 32'd0);
    step(0, 1, 5, 0, 0, 0, 0, 0);
    chk("lookup5_hist_after", 32'(pred_hist), 32'd0);

    // mispredict training index 2
    step(0, 0, 0, 1, 2, 0, 1, 0);
    chk("mp1_count", 32'(mispred_count), 32'd1);
    step(0, 0, 3, 0, 0, 0, 0, 0);
    chk("pc3_taken", 32'(pred_taken), 32'd1);
    chk("pc3_index", 32'(pred_index), 32'd2);
    chk("pc3_hist",  32'(pred_hist),  32'd1);

    // saturation on index 4
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 4, 0, 1, (m_pht[4] >= 2));
    peek(4, 1);
    step(0, 0, 0, 1, 4, 0, 0, (m_pht[4] >= 2));
    peek(4, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 4, 0, 0, (m_pht[4] >= 2));
    peek(4, 0);
    step(0, 0, 0, 1, 4, 0, 0, (m_pht[4] >= 2));
    peek(4, 0);

    // simultaneous lookup and mispredict: repair wins
    step(0, 0, 0, 1, 6, 1, 1, 0);
    chk("ghr_011", 32'(pred_hist), 32'd3);
    step(0, 1, 0, 1, 7, 2, 0, 1);
    chk("repair_ghr", 32'(pred_hist), 32'd4);

    // 2-bit statistics counter saturation
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 1, k, 0, 1, 0);
      chk("cnt2_seq", 32'(mispred_count_c2), 32'(cnt2_exp[k]));
    end

    // reset in same cycle as a mispredict
    step(0, 0, 0, 1, 3, 5, 1, 0);
    step(1, 1, 1, 1, 3, 5, 1, 0);
    chk("rstmp_count", 32'(mispred_count), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, i, 0, 0, 0, 0, 0);
      chk("rstmp_taken", 32'(pred_taken), 32'd0);
      chk("rstmp_hist",  32'(pred_hist),  32'd0);
    end

    // random phase
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
